ssd_source_arbiter: RTL
=======================

# ssd_source_arbiter

Time-shares the eight-digit seven-segment display between four requesters: CPU debug value, PC trace, UART status and memory test result. Each cycle the block picks one source in round-robin order, keeps it on screen for a minimum hold time, and drives the display driver's 32-bit hex value and decimal-point select. It sits between the debug/status producers and the display driver in the FPGA top level.

## Interface
Parameters:
- HOLD_CYCLES, 50000000, minimum cycles a granted source stays displayed while others wait (≥1)
- IDLE_VALUE, 32'h0000_0000, value shown when no source is granted

Ports:
- clk  in  1  single clock; all logic on posedge
- rstn  in  1  asynchronous, active-low reset
- req  in  4  per-source display request, level-sensitive
- val0, val1, val2, val3  in  32 each  hex value per source, 8 nibbles, nibble 0 = rightmost digit
- dp0, dp1, dp2, dp3  in  8 each  decimal-point select per source, bit i = 1 lights point of digit i
- pin  in  1  1 = freeze on current source, no rotation
- gnt  out  4  one-hot grant, 0 when idle
- active_src  out  2  index of granted source, 0 when idle
- bnumout  out  32  value to display driver
- dp_selout  out  8  decimal-point select to display driver
- switch_pulse  out  1  one-cycle strobe on every grant change, including to/from idle

## Operation
- States: IDLE, SHOW. Registers: state, gnt, last_src (2b), hold_cnt (32b), outputs.
- Round-robin search order: last_src+1, +2, +3, then last_src itself (mod 4). On reset last_src = 3, so source 0 has first priority.
- IDLE: if req ≠ 0, grant the first requesting source in search order, go to SHOW, hold_cnt = 0, last_src = new source. Otherwise stay idle.
- SHOW, granted req deasserted: release on the next edge, regardless of hold_cnt. If another req is set, grant it in search order; else go to IDLE.
- SHOW, hold_cnt < HOLD_CYCLES-1: increment hold_cnt.
- SHOW, hold_cnt == HOLD_CYCLES-1: hold_cnt saturates.
  - If pin = 0 and any other req is set, grant the next one in search order (excluding the current source) and clear hold_cnt.
  - If only the current source requests, keep it.
- pin = 1 only blocks hold-expiry rotation. It does not block release on req drop or grants from IDLE. When pin falls with the hold already expired and another req set, rotation happens on the next edge.
- In SHOW, bnumout and dp_selout are registered copies of val/dp of the granted source and track live input changes. In IDLE they are IDLE_VALUE and 8'h00.
- switch_pulse = 1 for exactly the cycle after any edge where gnt changed value.

## Timing
- Reset (async, immediate, no clock needed): state IDLE, gnt 0, active_src 0, bnumout IDLE_VALUE, dp_selout 8'h00, switch_pulse 0, hold_cnt 0, last_src 3.
- Grant latency: req sampled at edge t → gnt, active_src, bnumout, dp_selout all reflect the new source after edge t (same edge, no skew between them).
- Data latency: a change on the granted val/dp at edge t appears on bnumout/dp_selout after edge t.
- Hold: a source granted at edge t can lose the grant to rotation no earlier than edge t+HOLD_CYCLES.
  - With HOLD_CYCLES = 1 and several requesters, the grant rotates every cycle.
- Release on req drop: req low at edge t → new grant or IDLE after edge t.
- Simultaneous req drop and hold expiry: the release rule applies. The next source is picked by the same search order.
- Reset deassertion mid-operation: the first edge after rstn rises behaves as from IDLE.

## Test plan
- Reset with all req high, rstn low, no clock: gnt=0, bnumout=IDLE_VALUE, dp_selout=0, switch_pulse=0. Release rstn → first edge gnt=4'b0001, active_src=0.
- req=4'b0001, val0=32'h12345678, dp0=8'h04 → one edge later gnt=0001, bnumout=12345678, dp_selout=04, switch_pulse high one cycle. Change val0 to 32'hDEADBEEF → bnumout follows after one edge.
- HOLD_CYCLES=8, req=4'b1111 constant → grant sequence 0,1,2,3,0, each held exactly 8 cycles, switch_pulse every 8 cycles.
- HOLD_CYCLES=8, req=4'b0011, pin=1 → source 0 held for 20 cycles. Drop pin → gnt=0010 on the next edge.
- Source 2 granted, hold_cnt=3, req2 drops with req=4'b1000 → next edge gnt=1000. Then req=0 → IDLE, bnumout=IDLE_VALUE, switch_pulse on each change.
- Assert rstn low asynchronously mid-SHOW on source 3 → outputs reset immediately. After release with req=4'b1111 → source 0 is granted first.

Source files
------------

// File: rtl/ssd_source_arbiter.sv
// ssd_source_arbiter
//   Round-robin time-sharing of the 8-digit seven-segment display between
//   four sources (CPU debug, PC trace, UART status, memory test result).
//   A granted source stays on screen for at least HOLD_CYCLES cycles while
//   others wait. It is released at once when its own request drops.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing granted, display shows IDLE_VALUE with no points lit
//   SHOW  | source last_src granted, its val/dp copied to the driver
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   req[3:0]                   level-sensitive display requests
//   val0..val3 [31:0]          per-source hex value (nibble 0 = rightmost)
//   dp0..dp3 [7:0]             per-source decimal-point select
//   pin                        freeze on current source (blocks rotation only)
//   gnt[3:0], active_src[1:0]  one-hot grant / granted index (0 when idle)
//   bnumout[31:0], dp_selout   registered value/points to the display driver
//   switch_pulse               one-cycle strobe after any grant change
module ssd_source_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter logic [31:0] IDLE_VALUE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [31:0] val0,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] val3,
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
  input  logic [7:0]  dp2,
  input  logic [7:0]  dp3,
  input  logic        pin,
  output logic [3:0]  gnt,
  output logic [1:0]  active_src,
  output logic [31:0] bnumout,
  output logic [7:0]  dp_selout,
  output logic        switch_pulse
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_SHOW = 1'b1;
  localparam logic [31:0] HOLD_M1 = 32'(HOLD_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  last_src_q, last_src_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  active_q, active_d;
  logic [31:0] bnum_q, bnum_d;
  logic [7:0]  dp_q, dp_d;
  logic        pulse_q, pulse_d;
  logic [2:0]  pick;

  // Returns {found, index}. Search order is base+1, +2, +3 and finally base
  // itself, the last slot only when allow_base is set.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base,
                                         input logic       allow_base);
    logic [1:0] idx;
    logic       found;
    found   = 1'b0;
    rr_pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx] && (k < 4 || allow_base)) begin
        found   = 1'b1;
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    hold_cnt_d = hold_cnt_q;
    pick       = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          pick       = rr_pick(req, last_src_q, 1'b1);
          state_d    = ST_SHOW;
          last_src_d = pick[1:0];
          hold_cnt_d = '0;
        end
      end
      ST_SHOW: begin
        if (!req[last_src_q]) begin
          // Release wins over everything, including an expired hold.
          pick       = rr_pick(req, last_src_q, 1'b0);
          hold_cnt_d = '0;
          if (pick[2]) begin
            last_src_d = pick[1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_cnt_q < HOLD_M1) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end else if (!pin) begin
          // Hold expired and counter saturated; rotate only if someone waits.
          pick = rr_pick(req, last_src_q, 1'b0);
          if (pick[2]) begin
            last_src_d = pick[1:0];
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    gnt_d    = 4'b0000;
    active_d = 2'd0;
    bnum_d   = IDLE_VALUE;
    dp_d     = 8'h00;
    if (state_d == ST_SHOW) begin
      gnt_d    = 4'b0001 << last_src_d;
      active_d = last_src_d;
      case (last_src_d)
        2'd0:    begin bnum_d = val0; dp_d = dp0; end
        2'd1:    begin bnum_d = val1; dp_d = dp1; end
        2'd2:    begin bnum_d = val2; dp_d = dp2; end
        default: begin bnum_d = val3; dp_d = dp3; end
      endcase
    end
    pulse_d = (gnt_d != gnt_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      last_src_q <= 2'd3;
      hold_cnt_q <= '0;
      active_q   <= 2'd0;
      bnum_q     <= IDLE_VALUE;
      dp_q       <= 8'h00;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_src_q <= last_src_d;
      hold_cnt_q <= hold_cnt_d;
      active_q   <= active_d;
      bnum_q     <= bnum_d;
      dp_q       <= dp_d;
      pulse_q    <= pulse_d;
    end
  end

  assign gnt          = gnt_q;
  assign active_src   = active_q;
  assign bnumout      = bnum_q;
  assign dp_selout    = dp_q;
  assign switch_pulse = pulse_q;

endmodule
